// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_ack;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_ack;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;
    logic                  addr_sel;

    // Arbiter view.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_ack, if_rdata, d_ack, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, addr_sel
    );

    // Core requesters plus memory.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_ack, if_rdata, d_ack, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, addr_sel
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data sides; data has priority, bounded by a D-grant streak limit.
// Latency: grant registered one cycle after request, ack combinational on mem_ready; backpressure: request held until mem_ready.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t                state_q;
    logic [3:0]            streak_q;
    logic [3:0]            streak_d;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic                  addr_sel_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  d_win;

    // Streak only counts D grants that actually made fetch wait.
    always_comb begin
        d_win    = bus.d_req && (!bus.if_req || (streak_q < STREAK_MAX));
        streak_d = 4'd0;
        if (bus.if_req) begin
            streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            addr_sel_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (d_win) begin
                        state_q     <= BUSY_D;
                        streak_q    <= streak_d;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.d_we;
                        addr_sel_q  <= 1'b1;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                    end else if (bus.if_req) begin
                        state_q     <= BUSY_IF;
                        streak_q    <= 4'd0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        addr_sel_q  <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                    end else begin
                        mem_req_q   <= 1'b0;
                    end
                end
                BUSY_IF, BUSY_D: begin
                    if (bus.mem_ready) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_ack    = (state_q == BUSY_IF) && bus.mem_ready;
    assign bus.d_ack     = (state_q == BUSY_D)  && bus.mem_ready;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.addr_sel  = addr_sel_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requester sequences, a simple wait-state memory model,
// and a monitor that checks every ack against the queued expectation.
module tb_mem_port_arbiter;

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MAX_D_STREAK(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   wait_cycles = 0;
    int   mcnt = 0;
    exp_t exp_q[$];
    logic gl_sel[$];
    int   gl_cyc[$];
    logic mreq_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic is_d, input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata, input logic [31:0] rdata);
        exp_t e;
        e.is_d = is_d; e.addr = addr; e.we = we; e.wdata = wdata; e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    // Memory: ready after wait_cycles stalled cycles; read data = addr ^ 0x2008_0045.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!bus.mem_req) begin
                mcnt = 0;
                bus.mem_ready = 1'b0;
            end else begin
                if (mcnt == wait_cycles) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = bus.mem_addr ^ 32'h2008_0045;
                end else begin
                    bus.mem_ready = 1'b0;
                end
                mcnt++;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.if_ack || bus.d_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: if_ack=%0b d_ack=%0b with nothing outstanding",
                             bus.if_ack, bus.d_ack);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_side",  32'(bus.d_ack), 32'(e.is_d));
                    chk("ack_excl",  32'(bus.if_ack & bus.d_ack), 32'h0);
                    chk("ack_req",   32'(bus.mem_req), 32'h1);
                    chk("ack_addr",  bus.mem_addr, e.addr);
                    chk("ack_we",    32'(bus.mem_we), 32'(e.we));
                    chk("ack_wdata", bus.mem_wdata, e.wdata);
                    chk("ack_sel",   32'(bus.addr_sel), 32'(e.is_d));
                    if (!e.we) chk("ack_rdata", e.is_d ? bus.d_rdata : bus.if_rdata, e.rdata);
                end
            end
        end
    end

    // Grant logger: records side and cycle of each new memory request.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.mem_req && !mreq_prev) begin
                gl_sel.push_back(bus.addr_sel);
                gl_cyc.push_back(cyc);
                if (!bus.addr_sel) chk("streak_clear_on_if", 32'(dut.streak_q), 32'h0);
            end
            mreq_prev = bus.mem_req;
        end
    end

    task automatic wait_ack(input logic is_d);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (is_d ? bus.d_ack : bus.if_ack) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_ack_timeout: no ack within 50 cycles, required one", is_d ? "d" : "if");
        end
    endtask

    task automatic d_stream(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            bus.d_req   = 1'b1;
            bus.d_we    = 1'b0;
            bus.d_wdata = 32'h0;
            bus.d_addr  = base + 32'(4 * i);
            wait_ack(1'b1);
            @(posedge clk);
            #1;
        end
        bus.d_req = 1'b0;
    endtask

    task automatic if_stream(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            bus.if_req  = 1'b1;
            bus.if_addr = base + 32'(4 * i);
            wait_ack(1'b0);
            @(posedge clk);
            #1;
        end
        bus.if_req = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mem_req"},   32'(bus.mem_req), 32'h0);
        chk({tag, "_mem_we"},    32'(bus.mem_we), 32'h0);
        chk({tag, "_mem_addr"},  bus.mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        chk({tag, "_addr_sel"},  32'(bus.addr_sel), 32'h0);
        chk({tag, "_if_ack"},    32'(bus.if_ack), 32'h0);
        chk({tag, "_d_ack"},     32'(bus.d_ack), 32'h0);
    endtask

    initial begin
        logic [9:0] order;
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("por");
        @(posedge clk); #1; rst = 1'b0;

        // Reset in the middle of a stalled data access.
        wait_cycles = 100;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300; bus.d_wdata = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        chk("busy_d_req",  32'(bus.mem_req), 32'h1);
        chk("busy_d_sel",  32'(bus.addr_sel), 32'h1);
        chk("busy_d_addr", bus.mem_addr, 32'h300);
        #1; rst = 1'b1;
        #1;
        chk("rst_mem_req",  32'(bus.mem_req), 32'h0);
        chk("rst_addr_sel", 32'(bus.addr_sel), 32'h0);
        chk("rst_d_ack",    32'(bus.d_ack), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        bus.d_req = 1'b0; bus.d_wdata = 32'h0;
        @(posedge clk); #1; rst = 1'b0; wait_cycles = 0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("post_rst");

        // Single fetch, zero wait.
        @(posedge clk); #1;
        push_exp(1'b0, 32'h40, 1'b0, 32'h0, 32'h2008_0005);
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        @(negedge clk);
        chk("fetch_latency", 32'(bus.mem_req), 32'h0);
        @(negedge clk);
        chk("fetch_mem_req", 32'(bus.mem_req), 32'h1);
        chk("fetch_addr",    bus.mem_addr, 32'h40);
        chk("fetch_sel",     32'(bus.addr_sel), 32'h0);
        chk("fetch_ack",     32'(bus.if_ack), 32'h1);
        chk("fetch_rdata",   bus.if_rdata, 32'h2008_0005);
        @(posedge clk); #1; bus.if_req = 1'b0;
        @(negedge clk);
        chk("fetch_done_req", 32'(bus.mem_req), 32'h0);
        chk("fetch_done_ack", 32'(bus.if_ack), 32'h0);

        // Data write with three stalled cycles.
        wait_cycles = 3;
        @(posedge clk); #1;
        push_exp(1'b1, 32'h100, 1'b1, 32'hDEAD_BEEF, 32'h0);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("wr_mem_req", 32'(bus.mem_req), 32'h1);
            chk("wr_mem_we",  32'(bus.mem_we), 32'h1);
            chk("wr_wdata",   bus.mem_wdata, 32'hDEAD_BEEF);
            chk("wr_addr",    bus.mem_addr, 32'h100);
            chk("wr_d_ack",   32'(bus.d_ack), (k == 4) ? 32'h1 : 32'h0);
        end
        @(posedge clk); #1;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wdata = 32'h0; wait_cycles = 0;
        @(negedge clk);
        chk("wr_done_req", 32'(bus.mem_req), 32'h0);
        chk("wr_done_we",  32'(bus.mem_we), 32'h0);

        // Simultaneous requests: D first, then IF.
        @(posedge clk); #1;
        gl_sel.delete(); gl_cyc.delete();
        push_exp(1'b1, 32'h80, 1'b0, 32'h0, 32'h2008_00C5);
        push_exp(1'b0, 32'h44, 1'b0, 32'h0, 32'h2008_0001);
        fork
            d_stream(1, 32'h80);
            if_stream(1, 32'h44);
        join
        chk("sim_grant_count", 32'(gl_sel.size()), 32'd2);
        if (gl_sel.size() >= 2) begin
            chk("sim_first_sel",  32'(gl_sel[0]), 32'h1);
            chk("sim_second_sel", 32'(gl_sel[1]), 32'h0);
        end

        // Starvation limit with both sides continuously requesting.
        @(posedge clk); #1;
        gl_sel.delete(); gl_cyc.delete();
        push_exp(1'b1, 32'h200,  1'b0, 32'h0, 32'h2008_0245);
        push_exp(1'b1, 32'h204,  1'b0, 32'h0, 32'h2008_0241);
        push_exp(1'b1, 32'h208,  1'b0, 32'h0, 32'h2008_024D);
        push_exp(1'b1, 32'h20C,  1'b0, 32'h0, 32'h2008_0249);
        push_exp(1'b0, 32'h1000, 1'b0, 32'h0, 32'h2008_1045);
        push_exp(1'b1, 32'h210,  1'b0, 32'h0, 32'h2008_0255);
        push_exp(1'b1, 32'h214,  1'b0, 32'h0, 32'h2008_0251);
        push_exp(1'b1, 32'h218,  1'b0, 32'h0, 32'h2008_025D);
        push_exp(1'b1, 32'h21C,  1'b0, 32'h0, 32'h2008_0259);
        push_exp(1'b0, 32'h1004, 1'b0, 32'h0, 32'h2008_1041);
        fork
            d_stream(8, 32'h200);
            if_stream(2, 32'h1000);
        join
        order = 10'b01_1110_1111;
        chk("starve_grant_count", 32'(gl_sel.size()), 32'd10);
        for (int i = 0; i < 10 && i < gl_sel.size(); i++) begin
            chk($sformatf("starve_grant_%0d", i), 32'(gl_sel[i]), 32'(order[i]));
        end

        // Back-to-back loads with an address change after the first ack.
        @(posedge clk); #1;
        gl_sel.delete(); gl_cyc.delete();
        push_exp(1'b1, 32'h10, 1'b0, 32'h0, 32'h2008_0055);
        push_exp(1'b1, 32'h14, 1'b0, 32'h0, 32'h2008_0051);
        d_stream(2, 32'h10);
        chk("b2b_grant_count", 32'(gl_sel.size()), 32'd2);
        if (gl_cyc.size() >= 2) begin
            chk("b2b_idle_gap", 32'(gl_cyc[1] - gl_cyc[0]), 32'd2);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, required to finish");
        $fatal(1, "watchdog expired");
    end

endmodule
